// File: rtl/ae_event_packetizer.sv
// ---------------------------------------------------------------------------
// ae_event_packetizer
// Tags each granted pixel address from the arbiter with a free-running
// timestamp, buffers the tagged events in a first-word-fall-through FIFO,
// inserts a marker packet after every timestamp wrap, and presents the
// stream to the readout on a valid/ready interface.
//
// Ports
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   evt_valid_i  granted pixel present this cycle
//   x_add_i      granted pixel column address
//   y_add_i      granted pixel row address
//   hold_o       almost-full backpressure to the arbiter (advisory)
//   pkt_valid_o  packet available at FIFO head
//   pkt_data_o   head packet {type, y, x, ts} / {type, 0, 0, epoch}
//   pkt_ready_i  consumer accepts the head packet
//   overflow_o   sticky: at least one event dropped since reset
//   drop_cnt_o   saturating count of dropped events
//   occupancy_o  current FIFO fill level (0..DEPTH)
// ---------------------------------------------------------------------------
module ae_event_packetizer #(
    parameter  int unsigned ADD_W     = 4,
    parameter  int unsigned TS_W      = 16,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned AF_MARGIN = 2,
    parameter  int unsigned DROP_W    = 8,
    localparam int unsigned PKT_W     = 1 + 2 * ADD_W + TS_W,
    localparam int unsigned OCC_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              evt_valid_i,
    input  logic [ADD_W-1:0]  x_add_i,
    input  logic [ADD_W-1:0]  y_add_i,
    output logic              hold_o,
    output logic              pkt_valid_o,
    output logic [PKT_W-1:0]  pkt_data_o,
    input  logic              pkt_ready_i,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

    // Packet layout, MSB first; marker packets carry the epoch in the ts field.
    typedef struct packed {
        logic              marker;
        logic [ADD_W-1:0]  y;
        logic [ADD_W-1:0]  x;
        logic [TS_W-1:0]   ts;
    } pkt_t;

    // ---------------- state ----------------
    pkt_t              mem [DEPTH];
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   epoch_q;
    logic              wrap_pending_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    pkt_t              head_q;
    logic              valid_q;
    logic              hold_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_cnt_q;

    // ---------------- next-state ----------------
    logic              full;
    logic              pop;
    logic              evt_wr;
    logic              evt_drop;
    logic              mkr_wr;
    logic              push;
    pkt_t              wdata;
    logic [TS_W-1:0]   ts_d;
    logic [TS_W-1:0]   epoch_d;
    logic              wrap_pending_d;
    logic [AW-1:0]     wr_ptr_d;
    logic [AW-1:0]     rd_ptr_d;
    logic [OCC_W-1:0]  occ_d;
    pkt_t              head_d;
    logic              overflow_d;
    logic [DROP_W-1:0] drop_cnt_d;

    // Write arbitration, FIFO bookkeeping and counters.
    always_comb begin
        full           = 1'b0;
        pop            = 1'b0;
        evt_wr         = 1'b0;
        evt_drop       = 1'b0;
        mkr_wr         = 1'b0;
        push           = 1'b0;
        wdata          = '0;
        ts_d           = ts_q + TS_W'(1);
        epoch_d        = epoch_q;
        wrap_pending_d = wrap_pending_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        head_d         = '0;
        overflow_d     = overflow_q;
        drop_cnt_d     = drop_cnt_q;

        // Full is judged on the registered level: a same-cycle pop frees nothing.
        full     = (occ_q == OCC_W'(DEPTH));
        pop      = valid_q & pkt_ready_i;
        evt_wr   = evt_valid_i & ~full;
        evt_drop = evt_valid_i & full;
        mkr_wr   = wrap_pending_q & ~evt_valid_i & ~full;
        push     = evt_wr | mkr_wr;

        if (evt_valid_i) begin
            wdata.marker = 1'b0;
            wdata.y      = y_add_i;
            wdata.x      = x_add_i;
            wdata.ts     = ts_q;
        end else begin
            wdata.marker = 1'b1;
            wdata.ts     = epoch_q;
        end

        // A wrap arriving while a marker is still pending collapses into it.
        if (mkr_wr) begin
            wrap_pending_d = 1'b0;
        end
        if (ts_q == '1) begin
            wrap_pending_d = 1'b1;
            epoch_d        = epoch_q + TS_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        if (evt_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end

        // Head register: the new head is the entry being written when the
        // FIFO is otherwise empty, else whatever sits at the next read pointer.
        if (occ_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wdata;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Storage array; no reset needed, pointers and head register define contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q           <= '0;
            epoch_q        <= '0;
            wrap_pending_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            head_q         <= '0;
            valid_q        <= 1'b0;
            hold_q         <= 1'b0;
            overflow_q     <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            ts_q           <= ts_d;
            epoch_q        <= epoch_d;
            wrap_pending_q <= wrap_pending_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            head_q         <= head_d;
            valid_q        <= (occ_d != '0);
            hold_q         <= (occ_d >= OCC_W'(AF_LEVEL));
            overflow_q     <= overflow_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign hold_o      = hold_q;
    assign pkt_valid_o = valid_q;
    assign pkt_data_o  = head_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign occupancy_o = occ_q;

endmodule

// File: doc/ae_event_packetizer.md
Name: ae_event_packetizer

Overview:
- Downstream of the hierarchical pixel arbiter. Receives one granted pixel address per cycle (x/y from the top arbitration level) and tags it with a free-running timestamp.
- Buffers tagged events in a FIFO and presents them as address-event packets on a valid/ready stream to the readout interface.
- Inserts timestamp-wrap marker packets.
- Applies backpressure to the arbiter through hold_o, and counts events it has to drop.

Parameters:
- ADD_W, 4, width of each of x_add_i / y_add_i (16x16 array).
- TS_W, 16, timestamp counter width.
- DEPTH, 16, FIFO entries; power of 2, >= 4.
- AF_MARGIN, 2, hold_o asserts when occupancy >= DEPTH-AF_MARGIN.
- DROP_W, 8, dropped-event counter width.
- PKT_W, 1+2*ADD_W+TS_W, packet width (derived, not overridable).

Ports:
- clk_i, input, 1, clock.
- reset_i, input, 1, asynchronous active-high reset.
- evt_valid_i, input, 1, arbiter has a granted pixel this cycle (arbiter active_o).
- x_add_i, input, ADD_W, granted pixel column address.
- y_add_i, input, ADD_W, granted pixel row address.
- hold_o, output, 1, almost-full backpressure to the arbiter.
- pkt_valid_o, output, 1, packet available.
- pkt_data_o, output, PKT_W, packet at FIFO head.
- pkt_ready_i, input, 1, consumer accepts packet.
- overflow_o, output, 1, sticky: at least one event dropped since reset.
- drop_cnt_o, output, DROP_W, saturating count of dropped events.
- occupancy_o, output, $clog2(DEPTH)+1, current FIFO fill level.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on reset_i.
- Reset values: ts counter, epoch counter, FIFO pointers, occupancy_o, drop_cnt_o and overflow_o are 0. pkt_valid_o=0, hold_o=0, wrap_pending=0, pkt_data_o=0.
- Timestamp: ts increments by 1 every cycle and wraps from 2^TS_W-1 to 0. On the cycle ts==2^TS_W-1:
  - wrap_pending is set;
  - epoch increments, modulo 2^TS_W.
- Packet format, MSB first:
  - Event packet: {type=0, y_add, x_add, ts}. ts is the counter value in the capture cycle.
  - Marker packet: {type=1, 2*ADD_W zeros, epoch}. epoch is the value after its increment.
- Write arbitration: at most one FIFO write per cycle.
  - An event has priority over a marker.
  - The marker is written in the first cycle with wrap_pending=1, no event, and FIFO not full. wrap_pending clears on that write.
  - wrap_pending does not queue a second marker; it stays 1 until written.
- Event capture: when evt_valid_i=1, the event is written if the FIFO is not full.
  - Full is taken from the registered occupancy at the start of the cycle. A same-cycle pop does not free space for that cycle's write.
  - If full, the event is dropped: drop_cnt_o increments (saturating at 2^DROP_W-1) and overflow_o sets.
  - Events arriving while hold_o=1 are still accepted if not full. hold_o is advisory.
- hold_o: registered output, = (occupancy >= DEPTH-AF_MARGIN), computed from next-state occupancy. It reflects the fill level one cycle after the write.
- Read side:
  - First-word-fall-through. pkt_valid_o = (occupancy != 0). pkt_data_o = head entry.
  - A pop occurs when pkt_valid_o && pkt_ready_i.
  - pkt_data_o must hold stable while pkt_valid_o=1 and pkt_ready_i=0.
  - Latency: a write into an empty FIFO is visible on pkt_valid_o/pkt_data_o the next cycle.
- Simultaneous push and pop:
  - Not full: occupancy unchanged, both take effect.
  - Full: the pop takes effect, the push is dropped.
- Pointers wrap modulo DEPTH. occupancy_o is in the range 0..DEPTH.
- Reset mid-operation: all buffered packets are discarded immediately (asynchronous). pkt_valid_o drops to 0 without waiting for the clock.
- Ordering: packets leave in write order. Event timestamps are non-decreasing within one epoch.

Test Plan:
- Single event: after reset, drive evt_valid_i=1, x=3, y=5 at ts=10, pkt_ready_i=1 -> next cycle pkt_valid_o=1, pkt_data_o={0,4'h5,4'h3,16'd10}, popped; occupancy returns to 0.
- Fill and drop: pkt_ready_i=0, 18 consecutive events -> hold_o=1 once occupancy reaches 14; occupancy_o=16; drop_cnt_o=2; overflow_o=1. The 16 stored packets then drain in order with ts 0..15 offsets.
- Wrap marker collision: TS_W=4, event on ts=15 and on the following cycle -> both events written. The marker {1,0,0,epoch=1} is written on the first event-free cycle after them.
- Full push+pop: FIFO full, evt_valid_i=1 and pkt_ready_i=1 in the same cycle -> occupancy 15, drop_cnt_o+1, the head packet is popped.
- Backpressure stability: pkt_valid_o=1, pkt_ready_i held 0 for 5 cycles with new writes -> pkt_data_o unchanged; it advances only on ready.
- Async reset with 7 entries buffered: assert reset_i mid-cycle -> pkt_valid_o, occupancy_o, drop_cnt_o and overflow_o go to 0 before the next clk_i edge.
